// File: rtl/dmem_arbiter_if.sv
// Requester-side data memory port: req/gnt handshake plus read return path.
// The requester drives master; the arbiter consumes the slave view.
interface dmem_arbiter_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
);
    logic              req;
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              gnt;
    logic              rvalid;
    logic [DATA_W-1:0] rdata;

    modport master (
        output req, wr, addr, wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, wr, addr, wdata,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing a single-port sync-read data memory between CPU and HOST.
// Latency: gnt and memory bus one cycle after the sampled request, rvalid one cycle after gnt.
// Backpressure: the loser holds req and wins the next cycle; optional DMEM_ARBITER_HOST_LOCK_EN stalls the CPU.
module dmem_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
) (
    input  logic              clock,
    input  logic              reset,
    dmem_arbiter_if.slave     cpu,
    dmem_arbiter_if.slave     host,
`ifdef DMEM_ARBITER_HOST_LOCK_EN
    input  logic              host_lock,
`endif
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [1:0]        owner_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CPU  = 2'd1,
        HOST = 2'd2,
        LOCK = 2'd3
    } state_t;

    state_t state, state_nxt;
    logic   last_winner, last_winner_nxt;   // 1 = HOST won the last contended cycle
    logic   grant_cpu, grant_host;
    logic   cpu_gnt_q, host_gnt_q;
    logic   cpu_rvalid_q, host_rvalid_q;

    always_comb begin
        state_nxt       = IDLE;
        last_winner_nxt = last_winner;
        grant_cpu       = 1'b0;
        grant_host      = 1'b0;
`ifdef DMEM_ARBITER_HOST_LOCK_EN
        if (host_lock) begin
            state_nxt       = LOCK;
            grant_host      = host.req;
            last_winner_nxt = 1'b1;
        end else begin
`else
        begin
`endif
            if (cpu.req && host.req) begin
                grant_cpu       = last_winner;
                grant_host      = !last_winner;
                last_winner_nxt = !last_winner;
            end else begin
                grant_cpu  = cpu.req;
                grant_host = host.req;
            end
            if (grant_cpu)
                state_nxt = CPU;
            else if (grant_host)
                state_nxt = HOST;
            else
                state_nxt = IDLE;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= IDLE;
            last_winner   <= 1'b1;
            cpu_gnt_q     <= 1'b0;
            host_gnt_q    <= 1'b0;
            cpu_rvalid_q  <= 1'b0;
            host_rvalid_q <= 1'b0;
            mem_wr        <= 1'b0;
            mem_addr      <= '0;
            mem_wdata     <= '0;
        end else begin
            state         <= state_nxt;
            last_winner   <= last_winner_nxt;
            cpu_gnt_q     <= grant_cpu;
            host_gnt_q    <= grant_host;
            // A read's gnt cycle ends here; the sync memory returns its data in the next cycle.
            cpu_rvalid_q  <= cpu_gnt_q && !mem_wr;
            host_rvalid_q <= host_gnt_q && !mem_wr;
            if (grant_cpu) begin
                mem_addr  <= cpu.addr;
                mem_wdata <= cpu.wdata;
                mem_wr    <= cpu.wr;
            end else if (grant_host) begin
                mem_addr  <= host.addr;
                mem_wdata <= host.wdata;
                mem_wr    <= host.wr;
            end else begin
                mem_wr    <= 1'b0;
            end
        end
    end

    assign cpu.gnt     = cpu_gnt_q;
    assign host.gnt    = host_gnt_q;
    assign cpu.rvalid  = cpu_rvalid_q;
    assign host.rvalid = host_rvalid_q;
    assign cpu.rdata   = mem_rdata;
    assign host.rdata  = mem_rdata;
    assign owner_o     = state;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural 256x16 sync-read memory.
module tb_dmem_arbiter;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  mem_addr;
    logic        mem_wr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata = '0;
    logic [1:0]  owner_o;
    logic        host_lock = 1'b0;
    logic [15:0] mem [0:255];

    int errors = 0;
    int checks = 0;

    dmem_arbiter_if #(.ADDR_W(8), .DATA_W(16)) cpu_bus ();
    dmem_arbiter_if #(.ADDR_W(8), .DATA_W(16)) host_bus ();

    dmem_arbiter #(.ADDR_W(8), .DATA_W(16)) dut (
        .clock     (clock),
        .reset     (reset),
        .cpu       (cpu_bus.slave),
        .host      (host_bus.slave),
`ifdef DMEM_ARBITER_HOST_LOCK_EN
        .host_lock (host_lock),
`endif
        .mem_addr  (mem_addr),
        .mem_wr    (mem_wr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .owner_o   (owner_o)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (reset)
            mem[8'h10] <= 16'hBEEF;
        else if (mem_wr)
            mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem[mem_addr];
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_owner"},  32'(owner_o),         32'd0);
        check({tag, "_cgnt"},   32'(cpu_bus.gnt),     32'd0);
        check({tag, "_hgnt"},   32'(host_bus.gnt),    32'd0);
        check({tag, "_crv"},    32'(cpu_bus.rvalid),  32'd0);
        check({tag, "_hrv"},    32'(host_bus.rvalid), 32'd0);
        check({tag, "_memwr"},  32'(mem_wr),          32'd0);
        check({tag, "_maddr"},  32'(mem_addr),        32'd0);
        check({tag, "_mwdata"}, 32'(mem_wdata),       32'd0);
    endtask

    initial begin
        logic exp_cpu;
        for (int i = 0; i < 256; i++) mem[i] = '0;
        cpu_bus.req = 0;  cpu_bus.wr = 0;  cpu_bus.addr = '0;  cpu_bus.wdata = '0;
        host_bus.req = 0; host_bus.wr = 0; host_bus.addr = '0; host_bus.wdata = '0;

        // Reset state
        step(); step();
        check_reset_outputs("rst");
        reset = 0;

        // CPU read of preloaded 0x10
        cpu_bus.req = 1; cpu_bus.wr = 0; cpu_bus.addr = 8'h10;
        step();
        check("rd_cgnt",  32'(cpu_bus.gnt),  32'd1);
        check("rd_hgnt",  32'(host_bus.gnt), 32'd0);
        check("rd_maddr", 32'(mem_addr),     32'h10);
        check("rd_memwr", 32'(mem_wr),       32'd0);
        check("rd_owner", 32'(owner_o),      32'd1);
        cpu_bus.req = 0;
        step();
        check("rd_crv",    32'(cpu_bus.rvalid), 32'd1);
        check("rd_rdata",  32'(cpu_bus.rdata),  32'hBEEF);
        check("rd_cgnt2",  32'(cpu_bus.gnt),    32'd0);
        check("rd_owner2", 32'(owner_o),        32'd0);

        // Host write 0xA4 <= 0x1234, then CPU read of 0xA4
        host_bus.req = 1; host_bus.wr = 1; host_bus.addr = 8'hA4; host_bus.wdata = 16'h1234;
        step();
        check("hw_hgnt",   32'(host_bus.gnt), 32'd1);
        check("hw_memwr",  32'(mem_wr),       32'd1);
        check("hw_maddr",  32'(mem_addr),     32'hA4);
        check("hw_mwdata", 32'(mem_wdata),    32'h1234);
        check("hw_owner",  32'(owner_o),      32'd2);
        host_bus.req = 0;
        cpu_bus.req = 1; cpu_bus.wr = 0; cpu_bus.addr = 8'hA4;
        step();
        check("hw_cgnt",  32'(cpu_bus.gnt),     32'd1);
        check("hw_hrv",   32'(host_bus.rvalid), 32'd0);
        check("hw_memwr2", 32'(mem_wr),         32'd0);
        cpu_bus.req = 0;
        step();
        check("hw_crv",   32'(cpu_bus.rvalid), 32'd1);
        check("hw_rdata", 32'(cpu_bus.rdata),  32'h1234);

        // Contention from a fresh reset: strict alternation starting with CPU
        reset = 1; step(); reset = 0;
        cpu_bus.req = 1;  cpu_bus.wr = 0;  cpu_bus.addr = 8'h20;
        host_bus.req = 1; host_bus.wr = 0; host_bus.addr = 8'h30;
        for (int i = 0; i < 6; i++) begin
            step();
            exp_cpu = (i % 2 == 0);
            if (i == 5) begin cpu_bus.req = 0; host_bus.req = 0; end
            check($sformatf("ct%0d_cgnt", i),  32'(cpu_bus.gnt),  32'(exp_cpu));
            check($sformatf("ct%0d_hgnt", i),  32'(host_bus.gnt), 32'(!exp_cpu));
            check($sformatf("ct%0d_owner", i), 32'(owner_o),      exp_cpu ? 32'd1 : 32'd2);
            check($sformatf("ct%0d_maddr", i), 32'(mem_addr),     exp_cpu ? 32'h20 : 32'h30);
            check($sformatf("ct%0d_crv", i),   32'(cpu_bus.rvalid),  32'(i > 0 && !exp_cpu));
            check($sformatf("ct%0d_hrv", i),   32'(host_bus.rvalid), 32'(i > 0 && exp_cpu));
        end
        step();
        check("ct_end_hrv",   32'(host_bus.rvalid), 32'd1);
        check("ct_end_owner", 32'(owner_o),         32'd0);
        check("ct_end_gnts",  32'({cpu_bus.gnt, host_bus.gnt}), 32'd0);

        // Back-to-back CPU writes 0x00..0x03
        for (int i = 0; i < 4; i++) begin
            cpu_bus.req = 1; cpu_bus.wr = 1; cpu_bus.addr = 8'(i); cpu_bus.wdata = 16'(16'h0100 + i);
            step();
            check($sformatf("bb%0d_cgnt", i),   32'(cpu_bus.gnt), 32'd1);
            check($sformatf("bb%0d_maddr", i),  32'(mem_addr),    32'(i));
            check($sformatf("bb%0d_memwr", i),  32'(mem_wr),      32'd1);
            check($sformatf("bb%0d_mwdata", i), 32'(mem_wdata),   32'(16'h0100 + i));
        end
        cpu_bus.req = 0; cpu_bus.wr = 0;
        step();
        check("bb_end_cgnt",  32'(cpu_bus.gnt),    32'd0);
        check("bb_end_memwr", 32'(mem_wr),         32'd0);
        check("bb_end_maddr", 32'(mem_addr),       32'h03);
        check("bb_end_crv",   32'(cpu_bus.rvalid), 32'd0);
        check("bb_end_owner", 32'(owner_o),        32'd0);
        check("bb_mem2",      32'(mem[2]),         32'h0102);

        // Reset at the edge ending a CPU read's gnt cycle; host request at that edge is dropped
        cpu_bus.req = 1; cpu_bus.wr = 0; cpu_bus.addr = 8'h10;
        step();
        check("mr_cgnt", 32'(cpu_bus.gnt), 32'd1);
        cpu_bus.req = 0;
        host_bus.req = 1; host_bus.wr = 0; host_bus.addr = 8'h55;
        reset = 1;
        step();
        check_reset_outputs("mr");
        reset = 0; host_bus.req = 0;
        step();
        check("mr_post_crv",  32'(cpu_bus.rvalid), 32'd0);
        check("mr_post_hgnt", 32'(host_bus.gnt),   32'd0);

`ifdef DMEM_ARBITER_HOST_LOCK_EN
        // Host lock: CPU stalls, then the first contended grant after unlock goes to the CPU
        host_lock = 1;
        cpu_bus.req = 1;  cpu_bus.wr = 0;  cpu_bus.addr = 8'h11;
        host_bus.req = 1; host_bus.wr = 0; host_bus.addr = 8'h22;
        for (int i = 0; i < 4; i++) begin
            step();
            check($sformatf("lk%0d_hgnt", i),  32'(host_bus.gnt), 32'd1);
            check($sformatf("lk%0d_cgnt", i),  32'(cpu_bus.gnt),  32'd0);
            check($sformatf("lk%0d_owner", i), 32'(owner_o),      32'd3);
        end
        host_lock = 0;
        step();
        check("ul_cgnt",  32'(cpu_bus.gnt), 32'd1);
        check("ul_owner", 32'(owner_o),     32'd1);
        step();
        check("ul_hgnt",  32'(host_bus.gnt), 32'd1);
        cpu_bus.req = 0; host_bus.req = 0;
        step();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port 256x16 data memory between two requesters: the processor Controller/datapath (CPU port) and a host loader/debug port (HOST port).
- Sits between both requesters and the data memory, so the host can preload or inspect memory while the processor runs.
- Uses a registered req/gnt handshake, round-robin arbitration under contention and a 1-cycle synchronous-read return path.

Parameters:
- ADDR_W, 8, data memory address width.
- DATA_W, 16, data word width.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- cpu_req  in  1  CPU transfer request.
- cpu_wr  in  1  CPU transfer is a write (1) or a read (0).
- cpu_addr  in  ADDR_W  CPU address.
- cpu_wdata  in  DATA_W  CPU write data.
- cpu_gnt  out  1  CPU transfer accepted; high in the cycle the transfer is on the memory bus.
- cpu_rvalid  out  1  CPU read data valid.
- cpu_rdata  out  DATA_W  CPU read data.
- host_req, host_wr, host_addr, host_wdata  in  1/1/ADDR_W/DATA_W  host request fields, same meaning as the CPU fields.
- host_gnt, host_rvalid, host_rdata  out  1/1/DATA_W  host response fields, same meaning as the CPU fields.
- mem_addr  out  ADDR_W  memory address.
- mem_wr  out  1  memory write enable.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data; valid the cycle after the address is presented.
- owner_o  out  2  current FSM state: 0 IDLE, 1 CPU, 2 HOST, 3 LOCK.

Behaviour:
- Single clock domain (clock); reset is synchronous and active-high, sampled only on the rising edge.
- Reset values:
  - owner_o = 0 (IDLE); all gnt, rvalid and mem_wr = 0; mem_addr = 0; mem_wdata = 0.
  - last_winner = HOST, so the CPU wins the first tie.
- Handshake:
  - A requester holds req, wr, addr and wdata stable until it sees gnt.
  - The fields are sampled at edge k. If accepted, gnt is high for exactly one cycle, k to k+1.
  - During that gnt cycle, mem_addr/mem_wr/mem_wdata are registered copies of the winner's sampled fields.
  - A requester seeing gnt may change its fields in the same cycle and present the next transfer. Back-to-back grants to the same requester are allowed at 1 transfer per cycle.
- FSM (evaluated at every edge from the current requests):
  - No req: go to IDLE, mem_wr = 0 (mem_addr holds its last value).
  - One req: grant it (state CPU or HOST).
  - Both req: grant the requester that is not last_winner, then update last_winner. Strict alternation under continuous contention.
  - Any state can go to any state in one edge. No dead cycle between owners.
- Reads:
  - Edge k+1 ends the gnt cycle of a read; it sets that requester's rvalid for one cycle (k+1 to k+2).
  - cpu_rdata = host_rdata = mem_rdata, passed through combinationally. rdata is meaningful only while the matching rvalid is high.
- Writes: mem_wr = 1 only in the gnt cycle; no rvalid is produced.
- The ungranted requester keeps its req high and is served in the next arbitration cycle. Maximum wait under contention: 1 cycle.
- Reset during any cycle:
  - All gnt/rvalid/mem_wr drop at that edge; a pending rvalid is suppressed and lost.
  - Requests seen at the reset edge are discarded. Requesters must re-issue after reset deasserts.
- Address width: addresses are passed unmodified; no wrap or range check.

Optional Feature:
- Macro: DMEM_ARBITER_HOST_LOCK_EN.
- Defined:
  - Adds input host_lock (1 bit).
  - While host_lock = 1 at an edge, the FSM enters LOCK (owner_o = 3): only host requests are granted and cpu_req is ignored, so the CPU stalls.
  - A CPU read already in its rvalid cycle still completes.
  - Deasserting host_lock returns the FSM to normal arbitration at the next edge, with last_winner = HOST.
- Not defined: no host_lock port, LOCK is unreachable, and owner_o never equals 3.

Test Plan:
- CPU read:
  - Preload mem[0x10] = 0xBEEF; cpu_req = 1, cpu_wr = 0, cpu_addr = 0x10 for one edge.
  - Expect cpu_gnt = 1 the next cycle with mem_addr = 0x10, mem_wr = 0.
  - Expect cpu_rvalid = 1 and cpu_rdata = 0xBEEF the cycle after.
- Host write then CPU read of the same address:
  - host_wr to 0xA4 with data 0x1234, then CPU read of 0xA4.
  - Expect mem_wr = 1 with mem_wdata = 0x1234 in the host_gnt cycle; cpu_rdata = 0x1234 returned.
- Contention: both req held high for 6 cycles.
  - Expect grants in order CPU, HOST, CPU, HOST, CPU, HOST.
  - Expect owner_o toggling 1/2 and never both gnt high in one cycle.
- Back-to-back CPU transfers with no host activity: cpu writes to 0x00..0x03 on consecutive cycles.
  - Expect 4 consecutive cpu_gnt cycles, mem_addr stepping 0, 1, 2, 3, no gaps.
- Reset mid-read: assert reset at the edge ending a CPU read's gnt cycle.
  - Expect cpu_rvalid = 0 on the following cycle and owner_o = 0.
  - Expect all outputs at their reset values.
- With DMEM_ARBITER_HOST_LOCK_EN: host_lock = 1 with both requesting for 4 cycles.
  - Expect 4 host grants, no cpu_gnt, owner_o = 3.
  - After host_lock = 0, expect the first contended grant to go to the CPU.
